// File: rtl/branch_predictor.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | branch_predictor: 2-bit BHT + direct-mapped BTB fetch predictor          |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         if_pc,
  input  logic [31:0]         if_inst,
  input  logic                stall,
  input  logic                flush,
  output logic                pred_taken_if,
  output logic [31:0]         pred_target_if,
  output logic                prediction_id,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispredict,
  output logic [CNT_BITS-1:0] perf_branches,
  output logic [CNT_BITS-1:0] perf_mispred
);

  localparam int         ENTRIES   = 1 << IDX_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]          bht        [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                hit;
  logic                unused_bits;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign if_tag  = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  assign unused_bits = ^{if_pc[1:0], if_pc[31:IDX_BITS+TAG_BITS+2], if_inst[31:7],
                         upd_pc[1:0], upd_pc[31:IDX_BITS+TAG_BITS+2]};

  // Lookup reads the arrays directly, so a same-cycle update is seen only next cycle.
  assign hit            = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign pred_taken_if  = (if_inst[6:0] == OP_BRANCH) && bht[if_idx][1] && hit;
  assign pred_target_if = hit ? btb_target[if_idx] : (if_pc + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
      btb_valid <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
        btb_valid[upd_idx] <= 1'b1;
      end else if (bht[upd_idx] != 2'b00) begin
        bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

  // Tag and target payload carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prediction_id <= 1'b0;
    end else if (flush) begin
      prediction_id <= 1'b0;
    end else if (!stall) begin
      prediction_id <= pred_taken_if;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (upd_valid) begin
      if (perf_branches != '1) perf_branches <= perf_branches + CNT_BITS'(1);
      if (upd_mispredict && (perf_mispred != '1)) perf_mispred <= perf_mispred + CNT_BITS'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_branch_predictor: directed + random bench with a table-level model   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc, if_inst, upd_pc, upd_target;
  logic        stall, flush, upd_valid, upd_taken, upd_mispredict;
  logic        pred_taken_if, prediction_id;
  logic [31:0] pred_target_if;
  logic [15:0] perf_branches, perf_mispred;
  logic        s_taken, s_pid;
  logic [31:0] s_target;
  logic [3:0]  s_branches, s_mispred;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_inst(if_inst), .stall(stall), .flush(flush),
    .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if), .prediction_id(prediction_id),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  branch_predictor #(.CNT_BITS(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_inst(if_inst), .stall(stall), .flush(flush),
    .pred_taken_if(s_taken), .pred_target_if(s_target), .prediction_id(s_pid),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .perf_branches(s_branches), .perf_mispred(s_mispred)
  );

  int total = 0;
  int bad   = 0;

  int          m_ctr [64];
  bit          m_val [64];
  logic [7:0]  m_tag [64];
  logic [31:0] m_tgt [64];
  bit          m_pid;
  int          m_br, m_mis, ms_br, ms_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 0;
    end
    m_pid = 0; m_br = 0; m_mis = 0; ms_br = 0; ms_mis = 0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    return m_val[pc[7:2]] && (m_tag[pc[7:2]] == pc[15:8]);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc, input logic [31:0] inst);
    return (inst[6:0] == 7'h63) && (m_ctr[pc[7:2]] >= 2) && m_hit(pc);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[pc[7:2]] : pc + 32'd4;
  endfunction

  task automatic check_all();
    chk("pred_taken", {31'd0, pred_taken_if}, {31'd0, m_pred(if_pc, if_inst)});
    chk("pred_target", pred_target_if, m_target(if_pc));
    chk("prediction_id", {31'd0, prediction_id}, {31'd0, m_pid});
    chk("perf_branches", {16'd0, perf_branches}, m_br);
    chk("perf_mispred", {16'd0, perf_mispred}, m_mis);
    chk("small_branches", {28'd0, s_branches}, ms_br);
    chk("small_mispred", {28'd0, s_mispred}, ms_mis);
  endtask

  task automatic model_step();
    bit p;
    int i;
    p = m_pred(if_pc, if_inst);
    if (flush) m_pid = 0;
    else if (!stall) m_pid = p;
    if (upd_valid) begin
      i = upd_pc[7:2];
      if (upd_taken) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_val[i] = 1; m_tag[i] = upd_pc[15:8]; m_tgt[i] = upd_target;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
      if (m_br < 65535) m_br++;
      if (ms_br < 15) ms_br++;
      if (upd_mispredict) begin
        if (m_mis < 65535) m_mis++;
        if (ms_mis < 15) ms_mis++;
      end
    end
  endtask

  // Inputs are changed just after a rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tg, input bit mp);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispredict = mp;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0;
    if_pc = 32'h40; if_inst = 32'h0000_0063;
    set_upd(0, 0, 0, 0, 0);
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_taken", {31'd0, pred_taken_if}, 32'd0);
    chk("rst_target", pred_target_if, 32'h44);
    chk("rst_pid", {31'd0, prediction_id}, 32'd0);
    cycle();

    // First taken training makes the entry predict taken
    set_upd(1, 32'h40, 1, 32'h100, 1);
    cycle();
    set_upd(0, 0, 0, 0, 0);
    cycle();
    chk("trained_taken", {31'd0, pred_taken_if}, 32'd1);
    chk("trained_target", pred_target_if, 32'h100);
    chk("trained_pid", {31'd0, prediction_id}, 32'd1);

    // Saturate high, then two not-taken down to weakly not-taken
    for (int k = 0; k < 3; k++) begin
      set_upd(1, 32'h40, 1, 32'h100, 0);
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      set_upd(1, 32'h40, 0, 32'h0, 1);
      cycle();
    end
    set_upd(0, 0, 0, 0, 0);
    cycle();
    chk("weak_nt_taken", {31'd0, pred_taken_if}, 32'd0);
    chk("weak_nt_target", pred_target_if, 32'h100);

    // Aliasing index with a different tag misses
    if_pc = 32'h140;
    cycle();
    chk("alias_taken", {31'd0, pred_taken_if}, 32'd0);
    chk("alias_target", pred_target_if, 32'h144);

    // Same-cycle update and lookup: old state now, new state next cycle
    if_pc = 32'h40;
    set_upd(1, 32'h40, 1, 32'h100, 0);
    @(negedge clk);
    chk("war_old", {31'd0, pred_taken_if}, 32'd0);
    @(posedge clk); model_step(); #1;
    set_upd(0, 0, 0, 0, 0);
    chk("war_new", {31'd0, pred_taken_if}, 32'd1);
    cycle();

    // Stall freezes prediction_id; flush wins over stall
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      if_inst = (k % 2 == 0) ? 32'h0000_0013 : 32'h0000_0063;
      cycle();
      chk("stall_hold", {31'd0, prediction_id}, 32'd1);
    end
    flush = 1;
    cycle();
    chk("flush_over_stall", {31'd0, prediction_id}, 32'd0);
    stall = 0; flush = 0; if_inst = 32'h0000_0063;

    // Narrow counters saturate at all-ones
    for (int k = 0; k < 20; k++) begin
      set_upd(1, 32'h80, 1, 32'h200, 1);
      cycle();
    end
    chk("sat_branches", {28'd0, s_branches}, 32'hF);
    chk("sat_mispred", {28'd0, s_mispred}, 32'hF);

    // Asynchronous reset in the middle of an update
    set_upd(1, 32'h80, 1, 32'h300, 1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_branches", {16'd0, perf_branches}, 32'd0);
    chk("async_mispred", {16'd0, perf_mispred}, 32'd0);
    chk("async_pid", {31'd0, prediction_id}, 32'd0);
    #2 rst_n = 1'b1;
    set_upd(0, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) begin
      if_pc = k << 2;
      cycle();
      chk("post_rst_target", pred_target_if, (k << 2) + 4);
    end

    // Randomized traffic over a few aliasing addresses
    for (int k = 0; k < 800; k++) begin
      if_pc = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
      case ($urandom_range(0, 3))
        0, 1:    if_inst = {$urandom, 7'h63} >> 0;
        2:       if_inst = 32'h0000_006F;
        default: if_inst = 32'h0000_0013;
      endcase
      if_inst[6:0] = ($urandom_range(0, 3) < 2) ? 7'h63 : if_inst[6:0];
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_upd($urandom_range(0, 1), ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2),
              $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
